iob_cache_line_fill: RTL
========================

Name: iob_cache_line_fill

Overview:
- Back-end stage directly downstream of the AXI read channel.
- Captures the beats of a line-replacement burst (read_valid/read_addr/read_rdata) into a line buffer.
- When the burst completes, writes the whole line into the selected way of the cache data memory in one cycle.
- Reports completion to the cache controller.

Parameters:
- FE_DATA_W, 32, front-end word width in bits.
- BE_DATA_W, 64, back-end (AXI) beat width in bits; integer multiple of FE_DATA_W.
- LINE2BE_W, 2, log2(beats per line); 0 means a single-beat line.
- NLINES_W, 7, cache index width.
- NWAYS_W, 2, log2(number of ways); NWAYS = 2**NWAYS_W.
- Derived localparams:
  - BE2FE_W = log2(BE_DATA_W/FE_DATA_W)
  - WORD_OFFSET_W = LINE2BE_W + BE2FE_W
  - LINE_W = BE_DATA_W * 2**LINE2BE_W

Ports:
- clk_i  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- fill_start_i  in  1  one-cycle request from controller to start capturing a line.
- fill_index_i  in  NLINES_W  target line index, sampled with fill_start_i.
- fill_way_i  in  NWAYS_W  target way, sampled with fill_start_i.
- fill_word_i  in  WORD_OFFSET_W  requested FE word offset, sampled with fill_start_i.
- replace_i  in  1  busy flag from the read channel.
- read_valid_i  in  1  beat valid from the read channel.
- read_addr_i  in  max(LINE2BE_W,1)  beat index within line.
- read_rdata_i  in  BE_DATA_W  beat data.
- mem_we_o  out  NWAYS  one-hot way write enable.
- mem_addr_o  out  NLINES_W  data-memory index.
- mem_wdata_o  out  LINE_W  full line data.
- fill_busy_o  out  1  high in any state other than IDLE.
- fill_done_o  out  1  one-cycle completion pulse.
- fill_err_o  out  1  set with fill_done_o if any beat is missing.
- fwd_valid_o  out  1  critical-word forward strobe (feature only).
- fwd_rdata_o  out  FE_DATA_W  forwarded word (feature only).

Behaviour:
- Reset: state IDLE; all outputs 0; line buffer, beat mask, latched index/way/word and seen_replace all cleared.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - On fill_start_i: latch index/way/word, clear the beat mask and seen_replace, go to COLLECT.
  - read_valid_i is ignored in IDLE.
- COLLECT:
  - Each read_valid_i stores read_rdata_i into slot read_addr_i and sets mask bit read_addr_i.
  - A repeated beat index overwrites its slot. This covers the read channel re-issuing the burst after a slave error; replace_i stays high through the retry.
  - seen_replace is set when replace_i=1.
  - Transition to WRITE on the cycle seen_replace=1 and replace_i=0, i.e. the falling edge of replace_i.
  - If replace_i has not yet risen, remain in COLLECT.
- WRITE (exactly 1 cycle):
  - mem_we_o = one-hot(latched way); mem_addr_o = latched index.
  - mem_wdata_o = line buffer, beat k at bits [k*BE_DATA_W +: BE_DATA_W].
  - Next state: DONE.
- DONE (exactly 1 cycle):
  - fill_done_o=1.
  - fill_err_o = 1 if the mask is not all-ones, else 0.
  - Next state: IDLE.
- mem_we_o, fill_done_o and fill_err_o are 0 in every other state.
- Latency: fill_done_o asserts 2 cycles after replace_i falls.
- fill_start_i while busy: ignored; the current fill continues unchanged.
- read_valid_i in WRITE/DONE: ignored.
- Reset mid-fill: immediate return to IDLE; no memory write; no done pulse.
- LINE2BE_W=0: single slot; read_addr_i bit ignored; mask is 1 bit.

Optional Feature:
- Macro: IOB_CACHE_LINE_FILL_FWD_EN.
- Enabled:
  - In COLLECT, when read_valid_i=1 and read_addr_i equals the latched word[WORD_OFFSET_W-1:BE2FE_W], register fwd_valid_o=1 for one cycle.
  - fwd_rdata_o = FE word latched word[BE2FE_W-1:0] of that beat.
  - Forwarding happens at most once per fill; a retried burst does not re-forward.
- Disabled: fwd_valid_o and fwd_rdata_o are tied to 0 and no forwarding logic is built.

Test Plan:
- Defaults. fill_start with index=5, way=2; replace rises; beats 0..3 = 64'h0..0A0, 0..0A1, 0..0A2, 0..0A3 back-to-back; replace falls.
  -> One cycle later mem_we_o=4'b0100, mem_addr_o=5, mem_wdata_o = {A3,A2,A1,A0}. Next cycle fill_done_o=1, fill_err_o=0.
- Beats with 2-cycle gaps between each, plus fill_start_i pulsed mid-burst with way=1.
  -> Write still targets way 2, index 5; data is correct.
- Slave-error retry: beats 0..3 = 11..14, replace stays high, beats 0..3 = 21..24, then replace falls.
  -> Line written = {24,23,22,21}; exactly one mem_we_o pulse.
- Burst of only beats 0..2, then replace falls.
  -> Write occurs; fill_done_o=1 with fill_err_o=1.
- reset asserted after beat 1.
  -> mem_we_o never asserts; fill_busy_o=0. A following full fill completes normally.
- With IOB_CACHE_LINE_FILL_FWD_EN, fill_word=5, beat 2 = 64'hCAFE0000_BEEF0000.
  -> fwd_valid_o pulses once, the cycle after beat 2, with fwd_rdata_o=32'hCAFE0000. No second pulse on a retried burst.

Source files
------------

// File: rtl/iob_cache_line_fill.sv
// iob_cache_line_fill: captures the beats of a line-replacement read burst into a
// line buffer. When the burst ends it writes the whole line into one way of the
// cache data memory in a single cycle, then pulses done (with an error flag if a
// beat is missing).
// Optional macro IOB_CACHE_LINE_FILL_FWD_EN: forwards the requested critical word
// while the burst is still arriving.
module iob_cache_line_fill #(
  parameter int unsigned FE_DATA_W = 32,
  parameter int unsigned BE_DATA_W = 64,
  parameter int unsigned LINE2BE_W = 2,
  parameter int unsigned NLINES_W  = 7,
  parameter int unsigned NWAYS_W   = 2,
  localparam int unsigned BE2FE_W       = $clog2(BE_DATA_W / FE_DATA_W),
  localparam int unsigned WORD_OFFSET_W = LINE2BE_W + BE2FE_W,
  localparam int unsigned LINE_W        = BE_DATA_W * (2 ** LINE2BE_W),
  localparam int unsigned NWAYS         = 2 ** NWAYS_W,
  localparam int unsigned RADDR_W       = (LINE2BE_W > 0) ? LINE2BE_W : 1
) (
  input  logic                     clk_i,
  input  logic                     reset,
  input  logic                     fill_start_i,
  input  logic [NLINES_W-1:0]      fill_index_i,
  input  logic [NWAYS_W-1:0]       fill_way_i,
  input  logic [WORD_OFFSET_W-1:0] fill_word_i,
  input  logic                     replace_i,
  input  logic                     read_valid_i,
  input  logic [RADDR_W-1:0]       read_addr_i,
  input  logic [BE_DATA_W-1:0]     read_rdata_i,
  output logic [NWAYS-1:0]         mem_we_o,
  output logic [NLINES_W-1:0]      mem_addr_o,
  output logic [LINE_W-1:0]        mem_wdata_o,
  output logic                     fill_busy_o,
  output logic                     fill_done_o,
  output logic                     fill_err_o,
  output logic                     fwd_valid_o,
  output logic [FE_DATA_W-1:0]     fwd_rdata_o
);

  localparam int unsigned NBEATS    = 2 ** LINE2BE_W;
  localparam int unsigned FE_PER_BE = BE_DATA_W / FE_DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [LINE_W-1:0]        r_line, w_line_nxt;
  logic [NBEATS-1:0]        r_mask, w_mask_nxt;
  logic [NLINES_W-1:0]      r_index, w_index_nxt;
  logic [NWAYS_W-1:0]       r_way, w_way_nxt;
  logic [WORD_OFFSET_W-1:0] r_word, w_word_nxt;
  logic                     r_seen, w_seen_nxt;

  logic [NWAYS-1:0]         r_mem_we, w_mem_we_nxt;
  logic [NLINES_W-1:0]      r_mem_addr, w_mem_addr_nxt;
  logic [LINE_W-1:0]        r_mem_wdata, w_mem_wdata_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_done, w_done_nxt;
  logic                     r_err, w_err_nxt;

  // Single-beat lines have one slot, so the beat index is ignored.
  logic [RADDR_W-1:0]       w_slot;
  assign w_slot = (LINE2BE_W == 0) ? '0 : read_addr_i;

  // State, line buffer and registered outputs.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_line      <= '0;
      r_mask      <= '0;
      r_index     <= '0;
      r_way       <= '0;
      r_word      <= '0;
      r_seen      <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_line      <= w_line_nxt;
      r_mask      <= w_mask_nxt;
      r_index     <= w_index_nxt;
      r_way       <= w_way_nxt;
      r_word      <= w_word_nxt;
      r_seen      <= w_seen_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next state, beat capture, and next values of the registered outputs.
  // Outputs are computed from the state being entered so that they are valid
  // for the whole cycle spent in WRITE or DONE.
  always_comb begin
    w_state_nxt     = r_state;
    w_line_nxt      = r_line;
    w_mask_nxt      = r_mask;
    w_index_nxt     = r_index;
    w_way_nxt       = r_way;
    w_word_nxt      = r_word;
    w_seen_nxt      = r_seen;
    w_mem_we_nxt    = '0;
    w_mem_addr_nxt  = '0;
    w_mem_wdata_nxt = '0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;

    case (r_state)
      IDLE: begin
        if (fill_start_i) begin
          w_index_nxt = fill_index_i;
          w_way_nxt   = fill_way_i;
          w_word_nxt  = fill_word_i;
          w_mask_nxt  = '0;
          w_seen_nxt  = 1'b0;
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        // A retried burst simply overwrites earlier slots.
        if (read_valid_i) begin
          for (int unsigned k = 0; k < NBEATS; k++) begin
            if (w_slot == RADDR_W'(k)) begin
              w_line_nxt[k*BE_DATA_W +: BE_DATA_W] = read_rdata_i;
              w_mask_nxt[k] = 1'b1;
            end
          end
        end
        if (replace_i) begin
          w_seen_nxt = 1'b1;
        end else if (r_seen) begin
          w_state_nxt     = WRITE;
          w_mem_we_nxt    = NWAYS'(1) << r_way;
          w_mem_addr_nxt  = r_index;
          w_mem_wdata_nxt = w_line_nxt;
        end
      end
      WRITE: begin
        w_state_nxt = DONE;
        w_done_nxt  = 1'b1;
        w_err_nxt   = ~(&r_mask);
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign fill_busy_o = r_busy;
  assign fill_done_o = r_done;
  assign fill_err_o  = r_err;

`ifdef IOB_CACHE_LINE_FILL_FWD_EN
  logic                 r_fwd_valid, w_fwd_valid_nxt;
  logic [FE_DATA_W-1:0] r_fwd_rdata, w_fwd_rdata_nxt;
  logic                 r_fwd_done, w_fwd_done_nxt;
  logic [RADDR_W-1:0]   w_fwd_beat;
  int unsigned          w_fwd_fe;

  assign w_fwd_beat = RADDR_W'(r_word >> BE2FE_W);
  assign w_fwd_fe   = 32'(r_word) % FE_PER_BE;

  // Critical-word forward registers.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_fwd_valid <= 1'b0;
      r_fwd_rdata <= '0;
      r_fwd_done  <= 1'b0;
    end else begin
      r_fwd_valid <= w_fwd_valid_nxt;
      r_fwd_rdata <= w_fwd_rdata_nxt;
      r_fwd_done  <= w_fwd_done_nxt;
    end
  end

  // Forward the requested word once per fill; r_fwd_done blocks retries.
  always_comb begin
    w_fwd_valid_nxt = 1'b0;
    w_fwd_rdata_nxt = '0;
    w_fwd_done_nxt  = r_fwd_done;
    if ((r_state == IDLE) && fill_start_i) begin
      w_fwd_done_nxt = 1'b0;
    end else if ((r_state == COLLECT) && read_valid_i && !r_fwd_done &&
                 (w_slot == w_fwd_beat)) begin
      w_fwd_valid_nxt = 1'b1;
      w_fwd_rdata_nxt = FE_DATA_W'(read_rdata_i >> (FE_DATA_W * w_fwd_fe));
      w_fwd_done_nxt  = 1'b1;
    end
  end

  assign fwd_valid_o = r_fwd_valid;
  assign fwd_rdata_o = r_fwd_rdata;
`else
  // The latched word offset is only needed for forwarding.
  logic w_unused_word;
  assign w_unused_word = ^r_word;

  assign fwd_valid_o = 1'b0;
  assign fwd_rdata_o = '0;
`endif

endmodule
